mor1kx_spr_sysgrp_rd: RTL

- Read-access stage for the read-only system-group configuration SPRs: VR, VR2, UPR, CPUCFGR, DMMUCFGR, IMMUCFGR, DCCFGR, ICCFGR, DCFGR, PCCFGR and AVR.
- Consumes the static configuration register values and serves them to two requesters: the pipeline's l.mfspr/l.mtspr path (CPU port) and the debug unit (DU port).
- Provides round-robin arbitration, address decode, a registered response, and insertion of the pipeline implementation ID into VR2[7:0].

---
 rtl/mor1kx_spr_sysgrp_rd.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mor1kx_spr_sysgrp_rd.sv
// Read stage for the read-only system-group configuration SPRs.
// Arbitrates between the CPU and debug ports and returns a registered response.
module mor1kx_spr_sysgrp_rd #(
    parameter logic [7:0] OPTION_PIPELINE_ID = 8'h01,
    parameter string      FEATURE_DEBUGUNIT  = "NONE"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cfg_vr,
    input  logic [31:0] cfg_vr2,
    input  logic [31:0] cfg_upr,
    input  logic [31:0] cfg_cpucfgr,
    input  logic [31:0] cfg_dmmucfgr,
    input  logic [31:0] cfg_immucfgr,
    input  logic [31:0] cfg_dccfgr,
    input  logic [31:0] cfg_iccfgr,
    input  logic [31:0] cfg_dcfgr,
    input  logic [31:0] cfg_pccfgr,
    input  logic [31:0] cfg_avr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        du_req,
    input  logic        du_we,
    input  logic [15:0] du_addr,
    output logic        du_ack,
    output logic [31:0] du_rdata,
    output logic        du_err
);

    localparam bit DU_EN = (FEATURE_DEBUGUNIT != "NONE");

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state, state_next;
    logic        last_du;
    logic        du_req_eff;
    logic        grant_any, grant_du;
    logic        req_we;
    logic [15:0] req_addr;
    logic [32:0] lookup;
    logic        sel_err;
    logic [31:0] sel_rdata;
    logic        resp_du_p1;
    logic        resp_err_p1;
    logic [31:0] resp_rdata_p1;
    logic        vr2_id_unused;

    // The low byte of the VR2 input is replaced by the pipeline ID.
    assign vr2_id_unused = ^cfg_vr2[7:0];

    // Returns {hit, data}; hit only for group 0, indices 0..10.
    function automatic logic [32:0] spr_lookup(input logic [15:0] addr);
        logic [32:0] r;
        r = '0;
        if (addr[15:11] == 5'd0) begin
            case (addr[10:0])
                11'd0:   r = {1'b1, cfg_vr};
                11'd1:   r = {1'b1, cfg_upr};
                11'd2:   r = {1'b1, cfg_cpucfgr};
                11'd3:   r = {1'b1, cfg_dmmucfgr};
                11'd4:   r = {1'b1, cfg_immucfgr};
                11'd5:   r = {1'b1, cfg_dccfgr};
                11'd6:   r = {1'b1, cfg_iccfgr};
                11'd7:   r = {1'b1, cfg_dcfgr};
                11'd8:   r = {1'b1, cfg_pccfgr};
                11'd9:   r = {1'b1, cfg_vr2[31:8], OPTION_PIPELINE_ID};
                11'd10:  r = {1'b1, cfg_avr};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    assign du_req_eff = DU_EN && du_req;

    always_comb begin
        grant_any  = 1'b0;
        grant_du   = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                grant_any = cpu_req || du_req_eff;
                if (cpu_req && du_req_eff)
                    grant_du = !last_du;
                else
                    grant_du = du_req_eff;
                if (grant_any)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_we    = grant_du ? du_we : cpu_we;
    assign req_addr  = grant_du ? du_addr : cpu_addr;
    assign lookup    = spr_lookup(req_addr);
    assign sel_err   = !lookup[32] || req_we;
    assign sel_rdata = sel_err ? 32'd0 : lookup[31:0];

    // ---- grant edge: control registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_du    <= 1'b1;
            resp_du_p1 <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_any) begin
                last_du    <= grant_du;
                resp_du_p1 <= grant_du;
            end
        end
    end

    // ---- grant edge: response data, frozen while in RESP ----
    always_ff @(posedge clk) begin
        if (grant_any) begin
            resp_rdata_p1 <= sel_rdata;
            resp_err_p1   <= sel_err;
        end
    end

    assign cpu_ack   = (state == RESP) && !resp_du_p1;
    assign du_ack    = (state == RESP) && resp_du_p1;
    assign cpu_rdata = cpu_ack ? resp_rdata_p1 : 32'd0;
    assign cpu_err   = cpu_ack && resp_err_p1;
    assign du_rdata  = du_ack ? resp_rdata_p1 : 32'd0;
    assign du_err    = du_ack && resp_err_p1;

endmodule
